// File: rtl/adder_seq.sv
// ---------------------------------------------------------------------------
// adder_seq / adder32
//
// Purpose:
//   Time-multiplexed sum of a stream of N-bit operands, modulo 2^N.
//   All operands go through one shared adder32 instance, one operand per
//   cycle. This replaces the multi-input adder trees of the SHA-2 round
//   datapath. The control side issues `start` with an operand count. It then
//   streams operands over a valid/ready input and collects the reduced sum
//   over a valid/ready output.
//
// Ports (adder_seq):
//   clk        in   single clock, rising-edge
//   rst_n      in   synchronous, active-low reset
//   start      in   begin a new sum (only honoured in IDLE)
//   op_count   in   [CW-1:0] operand count, clamped to MAX_OPS
//   busy       out  high whenever not IDLE
//   in_valid   in   in_data is valid
//   in_ready   out  high only while accumulating
//   in_data    in   [N-1:0] operand
//   out_valid  out  high only when the result is presented
//   out_ready  in   consumer accepts the result
//   out_sum    out  [N-1:0] accumulated sum mod 2^N
//   out_ovf    out  sticky carry-out of bit N-1 over the whole sum
// ---------------------------------------------------------------------------

// Plain N-bit ripple-free behavioural adder. The carry is not exported, so
// the caller reconstructs it from the MSBs. That way one adder serves the
// whole datapath.
module adder32 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);

  assign s = a + b;

endmodule

module adder_seq #(
  parameter int N       = 32,
  parameter int MAX_OPS = 8,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] op_count,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_OPS_CW = CW'(MAX_OPS);
  localparam logic [CW-1:0] ONE_CW     = CW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] remaining_q, remaining_d;

  logic [N-1:0]  add_s;
  logic          add_carry;
  logic [CW-1:0] clamped_count;
  logic          in_hs;
  logic          out_hs;

  // The single shared adder: the accumulator plus the incoming operand.
  adder32 #(
    .N(N)
  ) u_adder (
    .a (acc_q),
    .b (in_data),
    .s (add_s)
  );

  // Carry out of the MSB, rebuilt from the operand and sum MSBs.
  // A carry occurs when both MSBs are set, or when one is set and the sum
  // MSB came out clear.
  assign add_carry = (acc_q[N-1] & in_data[N-1]) |
                     ((acc_q[N-1] | in_data[N-1]) & ~add_s[N-1]);

  assign clamped_count = (op_count > MAX_OPS_CW) ? MAX_OPS_CW : op_count;

  // The status outputs are pure decodes of the state register.
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Next-state logic.
  // acc/ovf are left untouched in DONE and on the return to IDLE. The
  // result therefore stays stable while presented, and it is only cleared
  // by the next accepted start.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          remaining_d = clamped_count;
          state_d     = (clamped_count == '0) ? DONE : ACCUM;
        end
      end

      ACCUM: begin
        if (in_hs) begin
          acc_d       = add_s;
          ovf_d       = ovf_q | add_carry;
          remaining_d = remaining_q - ONE_CW;
          if (remaining_q == ONE_CW) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset. A reset in the middle
  // of a sum discards all partial data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_adder_seq
//
// Purpose:
//   Directed self-checking bench for adder_seq. Each scenario task drives
//   its own stimulus and compares against hand-computed values.
//   Inputs change 1 time unit after the rising edge, and outputs are
//   sampled at that same point.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op_count;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;

  int n_checks;
  int n_fail;

  adder_seq #(
    .N(32),
    .MAX_OPS(8),
    .CW(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_count  (op_count),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance past one rising edge; inputs and samples live at edge + 1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for one cycle, then drop in_valid.
  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Issue a start with the given count for one edge.
  task automatic issue_start(input logic [3:0] cnt);
    start    = 1'b1;
    op_count = cnt;
    step();
    start    = 1'b0;
    op_count = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_sum: got %h expected 00000000", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    $display("[TB] basic: 1+2+3");
    out_ready = 1'b1;
    issue_start(4'd3);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_in_ready_c1: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_c1: got %b expected 1", busy); end
    feed(32'd1);
    feed(32'd2);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid); end
    feed(32'd3);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_out_valid_c4: got %b expected 1", out_valid); end
    n_checks++; if (out_sum !== 32'h00000006) begin n_fail++; $display("[TB] FAIL basic_sum: got %h expected 00000006", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf: got %b expected 0", out_ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_in_ready_done: got %b expected 0", in_ready); end
    step();
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle_c5: got busy=%b valid=%b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_carry();
    $display("[TB] carry: 6A09E667 + BB67AE85");
    out_ready = 1'b1;
    issue_start(4'd2);
    feed(32'h6A09E667);
    feed(32'hBB67AE85);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL carry_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sum !== 32'h257194EC) begin n_fail++; $display("[TB] FAIL carry_sum: got %h expected 257194ec", out_sum); end
    n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL carry_ovf: got %b expected 1", out_ovf); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL carry_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_clamp_wrap();
    $display("[TB] clamp: count 12 -> 8 operands of FFFFFFFF");
    out_ready = 1'b0;
    issue_start(4'd12);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_in_ready_%0d: got %b expected 1", i, in_ready); end
      // A start pulse in ACCUM must not restart or alter the sum.
      if (i == 3) begin
        start    = 1'b1;
        op_count = 4'd1;
      end
      feed(32'hFFFFFFFF);
      start    = 1'b0;
      op_count = '0;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sum !== 32'hFFFFFFF8) begin n_fail++; $display("[TB] FAIL clamp_sum: got %h expected fffffff8", out_sum); end
    n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_ovf: got %b expected 1", out_ovf); end
    // Further operands and a start in DONE must be ignored.
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    start    = 1'b1;
    op_count = 4'd2;
    step();
    in_valid = 1'b0;
    start    = 1'b0;
    op_count = '0;
    n_checks++; if (out_sum !== 32'hFFFFFFF8 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_hold: got sum=%h valid=%b expected fffffff8/1", out_sum, out_valid); end
    out_ready = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clamp_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_flow_control();
    logic [31:0] ops [4];
    ops[0] = 32'h10;
    ops[1] = 32'h20;
    ops[2] = 32'h30;
    ops[3] = 32'h40;
    $display("[TB] flow control: gapped input, stalled output");
    out_ready = 1'b0;
    issue_start(4'd4);
    for (int i = 0; i < 8; i++) begin
      // Odd cycles carry garbage with in_valid low; it must not be summed.
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? ops[i / 2] : 32'h0000DEAD;
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flow_valid_%0d: got %b expected 1", i, out_valid); end
      n_checks++; if (out_sum !== 32'h000000A0) begin n_fail++; $display("[TB] FAIL flow_sum_%0d: got %h expected 000000a0", i, out_sum); end
      step();
    end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL flow_ovf: got %b expected 0", out_ovf); end
    out_ready = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flow_idle: got busy=%b valid=%b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_zero_count();
    $display("[TB] zero count");
    out_ready = 1'b0;
    issue_start(4'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_valid_c1: got %b expected 1", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_sum: got %h expected 00000000", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_ovf_cleared: got %b expected 0", out_ovf); end
    out_ready = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_idle: got busy=%b in_ready=%b expected 0/0", busy, in_ready); end
  endtask

  task automatic test_reset_mid_sum();
    $display("[TB] reset mid-sum");
    out_ready = 1'b1;
    issue_start(4'd4);
    feed(32'h7);
    feed(32'h9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_ctrl: got busy=%b in_ready=%b valid=%b expected 0/0/0", busy, in_ready, out_valid); end
    n_checks++; if (out_sum !== 32'h0 || out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_data: got sum=%h ovf=%b expected 00000000/0", out_sum, out_ovf); end
    issue_start(4'd1);
    feed(32'h5);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_next_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sum !== 32'h00000005) begin n_fail++; $display("[TB] FAIL rst_next_sum: got %h expected 00000005", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_next_ovf: got %b expected 0", out_ovf); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_next_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op_count  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    test_reset();
    test_basic();
    test_carry();
    test_clamp_wrap();
    test_flow_control();
    test_zero_count();
    test_reset_mid_sum();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
# adder_seq

Sequencer that sums a stream of N-bit operands modulo 2^N on one shared `adder32` instance, one operand per cycle. It is the time-multiplexed replacement for adder trees in the SHA-2 round datapath. The compression/schedule control issues `start` with an operand count, streams the operands in (e.g. h, Σ1(e), Ch(e,f,g), K_t, W_t for T1), and collects the reduced sum over a valid/ready output.

## Interface
- `N`, 32: operand, accumulator and sum width. Passed through to `adder32`.
- `MAX_OPS`, 8: maximum operands per sum. Larger requests are clamped to this value.
- `CW`, 4: width of `op_count`. Must be ≥ clog2(MAX_OPS+1).
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: begin a new sum. Sampled only in IDLE.
- `op_count`, input, CW: number of operands for this sum (0..2^CW-1). Sampled with `start`.
- `busy`, output, 1: high in every state except IDLE.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: high only in ACCUM.
- `in_data`, input, N: operand.
- `out_valid`, output, 1: high only in DONE.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, N: accumulated sum mod 2^N. Stable while `out_valid` is high.
- `out_ovf`, output, 1: at least one add in this sum carried out of bit N-1.

## Operation
- One `adder32` instance (N = `N`). Its inputs are `acc` and `in_data`; its output feeds `acc`. No other adders exist in the block.
- Carry out of the MSB is derived locally as (a&b)|((a|b)&~s) on bit N-1.
- Registers:
  - `state` ∈ {IDLE, ACCUM, DONE}
  - `acc` [N-1:0]
  - `ovf`
  - `remaining` [CW-1:0]
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`: `acc`←0, `ovf`←0, `remaining`←min(`op_count`, MAX_OPS).
  - If the clamped count is 0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - On each cycle with `in_valid`&&`in_ready`: `acc`←`acc`+`in_data` (mod 2^N), `ovf`←`ovf`|carry, `remaining`←`remaining`-1.
  - If `remaining`==1 at that handshake, go to DONE.
  - Cycles with `in_valid`=0 change nothing.
- DONE:
  - `out_valid`=1, `out_sum`=`acc`, `out_ovf`=`ovf`.
  - Hold all values until `out_valid`&&`out_ready`, then go to IDLE.
- `start` asserted in ACCUM or DONE is ignored and has no effect on the current sum.
- `op_count` is only sampled with `start` in IDLE.
- `out_sum`/`out_ovf` are driven directly from `acc`/`ovf` in every state. Consumers must qualify them with `out_valid`.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, `acc`=0, `ovf`=0, `remaining`=0.
  - Outputs: `busy`=0, `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- Reset mid-operation (ACCUM or DONE) aborts the sum. No result is produced, and the next sum is unaffected by partial data.
- Latency:
  - `start` at edge 0 → `in_ready`=1 from cycle 1.
  - With K operands presented back-to-back, the K-th handshake is at edge K and `out_valid`=1 in cycle K+1.
  - Count 0: `out_valid`=1 in cycle 1.
- Throughput: one operand per cycle in ACCUM; no bubbles inserted.
- Result handshake at edge T → IDLE in cycle T+1. The earliest next `start` is sampled at edge T+1.
- Wrap-around: the sum is modulo 2^N. `out_ovf` is sticky across all adds of one sum and is cleared by the next accepted `start`.

## Test plan
- Basic: `start`, `op_count`=3, operands 1, 2, 3 back-to-back, `out_ready`=1 → `out_valid` in cycle 4, `out_sum`=0x00000006, `out_ovf`=0, IDLE in cycle 5.
- Carry: `op_count`=2, operands 0x6A09E667, 0xBB67AE85 → `out_sum`=0x257194EC, `out_ovf`=1.
- Wrap, clamp and ignored start:
  - `op_count`=12 (clamped to 8), eight operands of 0xFFFFFFFF → exactly 8 accepted, `out_sum`=0xFFFFFFF8, `out_ovf`=1.
  - `start` pulsed during ACCUM → no effect.
- Flow control:
  - `op_count`=4, operands 0x10, 0x20, 0x30, 0x40 with `in_valid` low on alternate cycles → only handshaked operands are summed.
  - Hold `out_ready` low for 3 cycles → `out_sum`=0xA0 held stable with `out_valid`=1, then IDLE one cycle after acceptance.
- Zero count: `op_count`=0 → `out_valid` in cycle 1, `out_sum`=0, `out_ovf`=0, `in_ready` never high.
- Reset mid-sum:
  - `op_count`=4, accept 0x7, 0x9, then `rst_n`=0 for one edge → all outputs 0, state IDLE.
  - Then `op_count`=1, operand 0x5 → `out_sum`=0x00000005, `out_ovf`=0.
